// File: rtl/psx_poll_master_if.sv
// Link pins to the controller plus the poll request/result bundle.
// master modport is the poll engine's view; slave is the controller/consumer side.
interface psx_poll_master_if;
  logic        start;
  logic        data;
  logic        ack;
  logic        psx_clk;
  logic        cmd;
  logic        att;
  logic        busy;
  logic        valid;
  logic        error;
  logic [1:0]  err_code;
  logic [7:0]  id;
  logic [15:0] buttons;

  modport master (
    input  start, data, ack,
    output psx_clk, cmd, att, busy, valid, error, err_code, id, buttons
  );

  modport slave (
    output start, data, ack,
    input  psx_clk, cmd, att, busy, valid, error, err_code, id, buttons
  );
endinterface

// File: rtl/psx_poll_master.sv
// PSX console-side poll engine: sends 01 42 00 00 00, collects id and buttons.
// One poll per accepted start; starts while busy or on the result cycle are dropped.
module psx_poll_master #(
  parameter int CLK_DIV     = 16,
  parameter int ATT_SETUP   = 32,
  parameter int ACK_TIMEOUT = 2048,
  parameter int ACK_SYNC    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  psx_poll_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, CLK_LO, CLK_HI, ACK_LO, ACK_HI, FINISH, ABORT
  } state_t;

  localparam int CNT_MAX = (ATT_SETUP > CLK_DIV) ? ATT_SETUP : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = ($clog2(ACK_TIMEOUT + 1) > 12) ? $clog2(ACK_TIMEOUT + 1) : 12;

  localparam logic [1:0] ERR_TMO    = 2'd1;
  localparam logic [1:0] ERR_ID     = 2'd2;
  localparam logic [1:0] ERR_MARKER = 2'd3;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [2:0]          byte_q, byte_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          id_buf_q, id_buf_d;
  logic [7:0]          lo_buf_q, lo_buf_d;
  logic [ACK_SYNC-1:0] ack_sync_q, ack_sync_d;
  logic [ACK_SYNC-1:0] data_sync_q, data_sync_d;
  logic                att_q, att_d;
  logic                psx_clk_q, psx_clk_d;
  logic                cmd_q, cmd_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [7:0]          id_q, id_d;
  logic [15:0]         buttons_q, buttons_d;

  logic       ack_s, data_s;
  logic [7:0] cur_cmd, nxt_cmd;
  logic       abort;
  logic [1:0] abort_code;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h01;
      3'd1:    cmd_byte = 8'h42;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign ack_s   = ack_sync_q[ACK_SYNC-1];
  assign data_s  = data_sync_q[ACK_SYNC-1];
  assign cur_cmd = cmd_byte(byte_q);
  assign nxt_cmd = cmd_byte(byte_q + 3'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    byte_d      = byte_q;
    bit_d       = bit_q;
    rx_d        = rx_q;
    id_buf_d    = id_buf_q;
    lo_buf_d    = lo_buf_q;
    att_d       = att_q;
    psx_clk_d   = psx_clk_q;
    cmd_d       = cmd_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    id_d        = id_q;
    buttons_d   = buttons_q;
    abort       = 1'b0;
    abort_code  = 2'd0;
    ack_sync_d  = {ack_sync_q[ACK_SYNC-2:0], bus.ack};
    data_sync_d = {data_sync_q[ACK_SYNC-2:0], bus.data};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          att_d   = 1'b0;
          busy_d  = 1'b1;
          byte_d  = 3'd0;
          bit_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(ATT_SETUP - 1)) begin
          state_d   = CLK_LO;
          cnt_d     = '0;
          psx_clk_d = 1'b0;
          cmd_d     = cur_cmd[bit_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLK_LO: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d   = CLK_HI;
          cnt_d     = '0;
          psx_clk_d = 1'b1;
          rx_d      = {data_s, rx_q[7:1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLK_HI: begin
        if (cnt_q != CNT_W'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            bit_d     = bit_q + 3'd1;
            state_d   = CLK_LO;
            psx_clk_d = 1'b0;
            cmd_d     = cur_cmd[bit_q + 3'd1];
          end else if (byte_q == 3'd1 && rx_q != 8'h41) begin
            abort      = 1'b1;
            abort_code = ERR_ID;
          end else if (byte_q == 3'd2 && rx_q != 8'h5A) begin
            abort      = 1'b1;
            abort_code = ERR_MARKER;
          end else if (byte_q == 3'd4) begin
            state_d = FINISH;
          end else begin
            state_d = ACK_LO;
            tmo_d   = '0;
            if (byte_q == 3'd1) id_buf_d = rx_q;
            if (byte_q == 3'd3) lo_buf_d = rx_q;
          end
        end
      end
      ACK_LO, ACK_HI: begin
        // ACK_LO waits for the low phase, ACK_HI for the release.
        if ((state_q == ACK_LO) && !ack_s) begin
          state_d = ACK_HI;
          tmo_d   = '0;
        end else if ((state_q == ACK_HI) && ack_s) begin
          state_d   = CLK_LO;
          byte_d    = byte_q + 3'd1;
          bit_d     = 3'd0;
          cnt_d     = '0;
          psx_clk_d = 1'b0;
          cmd_d     = nxt_cmd[0];
        end else if (tmo_q >= TMO_W'(ACK_TIMEOUT - 1)) begin
          abort      = 1'b1;
          abort_code = ERR_TMO;
        end else begin
          tmo_d = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
        end
      end
      FINISH: begin
        // valid is raised while still in FINISH so IDLE never shows a strobe.
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d      = cnt_q + 1'b1;
          att_d      = 1'b1;
          cmd_d      = 1'b1;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          err_code_d = 2'd0;
          buttons_d  = {rx_q, lo_buf_q};
          id_d       = id_buf_q;
        end else if (cnt_q == CNT_W'(CLK_DIV)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = ABORT;
      att_d      = 1'b1;
      psx_clk_d  = 1'b1;
      cmd_d      = 1'b1;
      error_d    = 1'b1;
      err_code_d = abort_code;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      byte_q      <= 3'd0;
      bit_q       <= 3'd0;
      rx_q        <= 8'h00;
      id_buf_q    <= 8'hFF;
      lo_buf_q    <= 8'hFF;
      ack_sync_q  <= '1;
      data_sync_q <= '1;
      att_q       <= 1'b1;
      psx_clk_q   <= 1'b1;
      cmd_q       <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      id_q        <= 8'hFF;
      buttons_q   <= 16'hFFFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      id_buf_q    <= id_buf_d;
      lo_buf_q    <= lo_buf_d;
      ack_sync_q  <= ack_sync_d;
      data_sync_q <= data_sync_d;
      att_q       <= att_d;
      psx_clk_q   <= psx_clk_d;
      cmd_q       <= cmd_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      id_q        <= id_d;
      buttons_q   <= buttons_d;
    end
  end

  assign bus.att      = att_q;
  assign bus.psx_clk  = psx_clk_q;
  assign bus.cmd      = cmd_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_code_q;
  assign bus.id       = id_q;
  assign bus.buttons  = buttons_q;

endmodule
